// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver slice.
//   rx_state_t           : receiver FSM states
//   DATA_W               : frame data width in bits
//   DEFAULT_CLKS_PER_BIT : default clock cycles per serial bit
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DATA_W               = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 1;

endpackage : uart_pkg

// File: rtl/receiver_uart_1_fsm_if.sv
// Bus bundle between the UART receiver and its consumer.
//   rx         : serial line into the receiver
//   dout       : received byte, stable while dout_valid is high
//   dout_valid : byte available, held until accepted
//   dout_ready : consumer accepts dout on dout_valid & dout_ready
//   frame_err  : one-cycle pulse on a bad stop bit
//   overrun    : sticky, a completed frame was dropped
//   busy       : receiver is inside a frame
// master = receiver side, slave = line driver / consumer side.
interface receiver_uart_1_fsm_if;
    import uart_pkg::*;

    logic              rx;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              frame_err;
    logic              overrun;
    logic              busy;

    modport master (
        input  rx,
        input  dout_ready,
        output dout,
        output dout_valid,
        output frame_err,
        output overrun,
        output busy
    );

    modport slave (
        output rx,
        output dout_ready,
        input  dout,
        input  dout_valid,
        input  frame_err,
        input  overrun,
        input  busy
    );

endinterface : receiver_uart_1_fsm_if

// File: rtl/uart_bit_timer.sv
// Bit-period counter with sample-point strobe.
//   clk    : clock
//   rst    : synchronous active-high reset
//   clear  : force the counter to index 0 on the next cycle
//   sample : high while the counter sits at the mid-bit index H
// The counter value is the index of the current cycle within the bit
// period and wraps from CLKS_PER_BIT-1 back to 0.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic sample
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

    logic [CNT_W-1:0] cnt;

    // NOTE: registers take <= so every flop samples pre-edge values;
    // blocking here would let later statements see updated state.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign sample = (cnt == HALF);

endmodule : uart_bit_timer

// File: rtl/receiver_uart_1_fsm.sv
// UART receiver: 8N1, LSB first, valid/ready output with overrun flag.
//   clk : clock, all logic on the rising edge
//   rst : synchronous active-high reset
//   bus : receiver_uart_1_fsm_if.master (rx, dout, dout_valid,
//         dout_ready, frame_err, overrun, busy)
// The start-detection cycle is index 0 of the start bit; every later
// decision is taken at the mid-bit index H reported by the bit timer.
module receiver_uart_1_fsm
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                   clk,
    input  logic                   rst,
    receiver_uart_1_fsm_if.master  bus
);

    localparam int H = (CLKS_PER_BIT - 1) / 2;

    rx_state_t         state;
    logic              armed;
    logic [DATA_W-1:0] shift;
    logic [2:0]        bit_idx;
    logic              sample;
    logic              start_det;
    logic              timer_clear;

    // A start needs a preceding high cycle, so a line stuck low after
    // reset or after a bad stop bit cannot fake a frame.
    assign start_det = (state == IDLE) && armed && !bus.rx;

    // Hold the counter at 0 while idle and whenever the next state is IDLE,
    // so start detection always lands on index 0.
    // NOTE: defaulting every always_comb output first rules out latches.
    always_comb begin
        timer_clear = 1'b0;
        unique case (state)
            IDLE:    timer_clear = !start_det;
            START:   timer_clear = sample && bus.rx;
            DATA:    timer_clear = 1'b0;
            STOP:    timer_clear = sample;
            default: timer_clear = 1'b1;
        endcase
    end

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .sample (sample)
    );

    // NOTE: the shift register is reset too, so the datapath comes up in
    // a known state rather than relying on the frame to overwrite it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            armed          <= 1'b0;
            shift          <= '0;
            bit_idx        <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.overrun    <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.frame_err <= 1'b0;

            // Handshake retires the byte; a load or overrun set below wins.
            if (bus.dout_valid && bus.dout_ready) begin
                bus.dout_valid <= 1'b0;
                bus.overrun    <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (bus.rx) begin
                        armed <= 1'b1;
                    end
                    if (start_det) begin
                        armed    <= 1'b0;
                        bit_idx  <= '0;
                        bus.busy <= 1'b1;
                        // With H == 0 this cycle is also the start sample.
                        state    <= (H == 0) ? DATA : START;
                    end
                end

                START: begin
                    if (sample) begin
                        if (bus.rx) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (sample) begin
                        shift   <= {bus.rx, shift[DATA_W-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end

                STOP: begin
                    if (sample) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        if (bus.rx) begin
                            // Stop bit is a high cycle: arms back-to-back frames.
                            armed <= 1'b1;
                            if (!bus.dout_valid || bus.dout_ready) begin
                                bus.dout       <= shift;
                                bus.dout_valid <= 1'b1;
                            end else begin
                                bus.overrun <= 1'b1;
                            end
                        end else begin
                            bus.frame_err <= 1'b1;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule : receiver_uart_1_fsm
